pic_inta_sequencer: RTL
=======================

# pic_inta_sequencer

Interrupt-acknowledge sequencer for the 8259-compatible PIC: the CPU-facing end of the request path. It raises INT toward the CPU when the priority resolver reports a pending request. It then walks the INTA pulse sequence (two pulses in 8086 mode, three in 8080 mode), and in that sequence it issues the one-hot `clear_irr` and `set_isr` strobes back to the IRR/ISR, drives the vector or CALL bytes onto the data bus, and issues the AEOI strobe.

## Interface
Parameters: none.

Ports (`name direction width meaning`):
- `clk  in  1` Single system clock; all logic is on the rising edge.
- `rst_n  in  1` Reset, asynchronous, active-low.
- `intr_req  in  1` The priority resolver has an unmasked request that outranks the in-service level.
- `req_level  in  3` Highest-priority pending IR level; valid when `intr_req`=1.
- `inta_n  in  1` CPU interrupt acknowledge, active-low, synchronous to `clk`.
- `mode_8086  in  1` From ICW4. 1 = 8086 (2 pulses), 0 = 8080 (3 pulses).
- `aeoi  in  1` From ICW4: automatic EOI.
- `icw1_addr  in  3` ICW1 A7..A5 (used in 8080 mode).
- `icw1_adi  in  1` Call-address interval. 1 = 4 bytes, 0 = 8 bytes.
- `icw2  in  8` ICW2 byte.
- `int_out  out  1` INT to the CPU.
- `clear_irr  out  8` One-cycle one-hot strobe to the IRR.
- `set_isr  out  8` One-cycle one-hot strobe to the ISR.
- `aeoi_clr_isr  out  8` One-cycle one-hot AEOI strobe to the ISR.
- `freeze  out  1` Holds IRR/priority inputs stable for the whole acknowledge sequence.
- `data_out  out  8` Byte for the data bus.
- `data_oe  out  1` Data-bus drive enable.

## Operation
- States: IDLE, ACK1, ACK2, ACK3. A state name is the most recently started INTA pulse.
- Fall event: `inta_n_q`=1 and `inta_n`=0. Rise event: `inta_n_q`=0 and `inta_n`=1. `inta_n_q` resets to 1.
- **IDLE**
  - `int_out` <= `intr_req`.
  - On a fall event:
    - Latch `mode_8086`, `aeoi`, and the level.
    - If `intr_req`=1, level = `req_level`; pulse `clear_irr` and `set_isr` at bit `req_level`.
    - If `intr_req`=0 (spurious), level = 7; no `clear_irr`/`set_isr` pulse; a spurious sequence never pulses `aeoi_clr_isr`.
    - Set `int_out`=0 and `freeze`=1; go to ACK1.
- **ACK1**
  - The next fall event goes to ACK2.
- **ACK2**
  - 8086 mode: the rise event ends the sequence.
  - 8080 mode: the next fall event goes to ACK3.
- **ACK3** (8080 only)
  - The rise event ends the sequence.
- **End of sequence**
  - Pulse `aeoi_clr_isr` at bit level if `aeoi`=1 and the sequence was not spurious.
  - `freeze`=0; go to IDLE.
- **Bytes driven on `data_out`**
  - 8086, pulse 1: nothing driven.
  - 8086, pulse 2: {`icw2[7:3]`, level}.
  - 8080, pulse 1: 8'hCD.
  - 8080, pulse 2, ADI=1: {`icw1_addr`, level, 2'b00}.
  - 8080, pulse 2, ADI=0: {`icw1_addr[2:1]`, level, 3'b000}.
  - 8080, pulse 3: `icw2`.
- Rise events in IDLE are ignored.
- Changes on `intr_req`/`req_level` and ICW inputs outside IDLE are ignored.

## Timing
- Reset values: `int_out`=0, all strobes 0, `freeze`=0, `data_out`=8'h00, `data_oe`=0, state IDLE.
- All outputs are registered. Each response appears on the cycle after the sampled event edge.
- `clear_irr`/`set_isr` are exactly 1 cycle wide, on the cycle after the first fall event.
- `aeoi_clr_isr` is 1 cycle wide, on the cycle after the final rise event.
- `data_oe`=1 from the cycle after a data-pulse fall to the cycle after its rise (exclusive). `data_out` is valid whenever `data_oe`=1 and is 0 otherwise.
- `int_out` drops the cycle after the first fall. It can re-assert no earlier than 2 cycles after the final rise.
- An INTA pulse low for 1 cycle is legal; the same fall/rise rules apply.
- Asynchronous reset mid-sequence:
  - All outputs clear immediately; state goes to IDLE.
  - No AEOI strobe is issued.
  - A pulse already in progress is ignored until its rise.

## Structure
- Shared package `pic_pkg`:
  - state enum `inta_state_t`
  - `CALL_OPCODE` = 8'hCD
  - `SPURIOUS_LEVEL` = 3'd7
- Natural sub-module: combinational `pic_vector_mux` (mode, pulse index, ADI, ICW fields, level -> byte).

## Test plan
- **8086 normal:** `icw2`=8'h40, `req_level`=3, `intr_req`=1, two INTA pulses.
  - `clear_irr`/`set_isr`=8'h08 for 1 cycle after the first fall.
  - Second pulse drives 8'h43.
  - `int_out` falls after the first fall.
- **8080, ADI=1:** `icw1_addr`=3'b101, level 2, `icw2`=8'h12.
  - Bytes driven: CD, A8, 12.
- **8080, ADI=0:** `icw1_addr`=3'b110, level 5.
  - Second byte is 8'hE8.
- **Spurious:** `intr_req`=0 at the first fall, `aeoi`=1, 8086 mode, `icw2`=8'h40.
  - Vector is 8'h47.
  - No `clear_irr`/`set_isr`/`aeoi_clr_isr` pulse.
- **AEOI:** `aeoi`=1, level 6.
  - `aeoi_clr_isr`=8'h40 for 1 cycle after the last rise.
  - `req_level` changed mid-sequence has no effect.
- **Reset mid-sequence:** assert `rst_n`=0 in ACK2 (8080 mode).
  - Outputs are 0 and `data_oe`=0 immediately.
  - A new request after reset is acknowledged normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible PIC acknowledge path.
package pic_pkg;

    // Acknowledge sequencer states; a state names the most recently started INTA pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2,
        ST_ACK3 = 2'd3
    } inta_state_t;

    localparam logic [7:0] CALL_OPCODE    = 8'hCD;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // One-hot decode of an IR level onto the 8-bit IRR/ISR strobe buses.
    function automatic logic [7:0] level_onehot(input logic [2:0] level);
        logic [7:0] mask;
        mask = 8'h00;
        mask[level] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/pic_vector_mux.sv
// Selects the byte the PIC drives for a given INTA pulse from mode, ICW fields and level.
module pic_vector_mux
    import pic_pkg::*;
(
    input  logic       mode_8086,
    input  logic [1:0] pulse_idx,
    input  logic       adi,
    input  logic [2:0] icw1_addr,
    input  logic [7:0] icw2,
    input  logic [2:0] level,
    output logic [7:0] byte_out,
    output logic       byte_valid
);

    // Byte and drive-enable for the pulse about to start (1, 2 or 3).
    always_comb begin
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        case (pulse_idx)
            2'd1: begin
                if (mode_8086) begin
                    byte_out   = 8'h00;
                    byte_valid = 1'b0;
                end else begin
                    byte_out   = CALL_OPCODE;
                    byte_valid = 1'b1;
                end
            end
            2'd2: begin
                byte_valid = 1'b1;
                if (mode_8086) begin
                    byte_out = {icw2[7:3], level};
                end else if (adi) begin
                    byte_out = {icw1_addr, level, 2'b00};
                end else begin
                    byte_out = {icw1_addr[2:1], level, 3'b000};
                end
            end
            2'd3: begin
                if (mode_8086) begin
                    byte_out   = 8'h00;
                    byte_valid = 1'b0;
                end else begin
                    byte_out   = icw2;
                    byte_valid = 1'b1;
                end
            end
            default: begin
                byte_out   = 8'h00;
                byte_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-facing interrupt acknowledge sequencer: raises INT, walks the INTA pulses,
// strobes IRR/ISR, drives vector/CALL bytes and issues the AEOI strobe.
module pic_inta_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       intr_req,
    input  logic [2:0] req_level,
    input  logic       inta_n,
    input  logic       mode_8086,
    input  logic       aeoi,
    input  logic [2:0] icw1_addr,
    input  logic       icw1_adi,
    input  logic [7:0] icw2,
    output logic       int_out,
    output logic [7:0] clear_irr,
    output logic [7:0] set_isr,
    output logic [7:0] aeoi_clr_isr,
    output logic       freeze,
    output logic [7:0] data_out,
    output logic       data_oe
);

    inta_state_t state_q, state_d;
    logic        inta_n_q, inta_n_d;
    logic        ign_q, ign_d;
    logic        mode_q, mode_d;
    logic        aeoi_q, aeoi_d;
    logic        spur_q, spur_d;
    logic [2:0]  level_q, level_d;
    logic [2:0]  addr_q, addr_d;
    logic        adi_q, adi_d;
    logic [7:0]  icw2_q, icw2_d;

    logic        int_out_q, int_out_d;
    logic [7:0]  clear_irr_q, clear_irr_d;
    logic [7:0]  set_isr_q, set_isr_d;
    logic [7:0]  aeoi_clr_q, aeoi_clr_d;
    logic        freeze_q, freeze_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;

    logic        fall_s, rise_s, in_idle_s;
    logic [2:0]  live_level_s;
    logic        sel_mode_s, sel_adi_s;
    logic [2:0]  sel_addr_s, sel_level_s;
    logic [7:0]  sel_icw2_s;
    logic [1:0]  pulse_idx_s;
    logic [7:0]  mux_byte_s;
    logic        mux_valid_s;

    // Edge detection on the synchronous INTA input; a pulse already low when
    // reset releases is masked until INTA has been seen high again.
    always_comb begin
        fall_s       = inta_n_q & ~inta_n & ~ign_q;
        rise_s       = ~inta_n_q & inta_n;
        ign_d        = ign_q & ~inta_n;
        inta_n_d     = inta_n;
        in_idle_s    = (state_q == ST_IDLE);
        live_level_s = intr_req ? req_level : SPURIOUS_LEVEL;
    end

    // In IDLE the vector mux looks at live inputs (first pulse); afterwards
    // it uses the values captured at the first fall.
    always_comb begin
        if (in_idle_s) begin
            sel_mode_s  = mode_8086;
            sel_adi_s   = icw1_adi;
            sel_addr_s  = icw1_addr;
            sel_icw2_s  = icw2;
            sel_level_s = live_level_s;
        end else begin
            sel_mode_s  = mode_q;
            sel_adi_s   = adi_q;
            sel_addr_s  = addr_q;
            sel_icw2_s  = icw2_q;
            sel_level_s = level_q;
        end
        case (state_q)
            ST_IDLE: pulse_idx_s = 2'd1;
            ST_ACK1: pulse_idx_s = 2'd2;
            ST_ACK2: pulse_idx_s = 2'd3;
            default: pulse_idx_s = 2'd0;
        endcase
    end

    pic_vector_mux u_vector_mux (
        .mode_8086  (sel_mode_s),
        .pulse_idx  (pulse_idx_s),
        .adi        (sel_adi_s),
        .icw1_addr  (sel_addr_s),
        .icw2       (sel_icw2_s),
        .level      (sel_level_s),
        .byte_out   (mux_byte_s),
        .byte_valid (mux_valid_s)
    );

    // Next-state and next-output computation for the acknowledge sequence.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        aeoi_d      = aeoi_q;
        spur_d      = spur_q;
        level_d     = level_q;
        addr_d      = addr_q;
        adi_d       = adi_q;
        icw2_d      = icw2_q;
        int_out_d   = 1'b0;
        clear_irr_d = 8'h00;
        set_isr_d   = 8'h00;
        aeoi_clr_d  = 8'h00;
        freeze_d    = freeze_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;

        case (state_q)
            ST_IDLE: begin
                int_out_d  = intr_req;
                freeze_d   = 1'b0;
                data_oe_d  = 1'b0;
                data_out_d = 8'h00;
                if (fall_s) begin
                    mode_d    = mode_8086;
                    aeoi_d    = aeoi;
                    spur_d    = ~intr_req;
                    level_d   = live_level_s;
                    addr_d    = icw1_addr;
                    adi_d     = icw1_adi;
                    icw2_d    = icw2;
                    if (intr_req) begin
                        clear_irr_d = level_onehot(req_level);
                        set_isr_d   = level_onehot(req_level);
                    end else begin
                        clear_irr_d = 8'h00;
                        set_isr_d   = 8'h00;
                    end
                    int_out_d  = 1'b0;
                    freeze_d   = 1'b1;
                    data_oe_d  = mux_valid_s;
                    data_out_d = mux_valid_s ? mux_byte_s : 8'h00;
                    state_d    = ST_ACK1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1: begin
                if (rise_s) begin
                    data_oe_d  = 1'b0;
                    data_out_d = 8'h00;
                end else if (fall_s) begin
                    data_oe_d  = mux_valid_s;
                    data_out_d = mux_valid_s ? mux_byte_s : 8'h00;
                    state_d    = ST_ACK2;
                end else begin
                    state_d = ST_ACK1;
                end
            end
            ST_ACK2: begin
                if (rise_s) begin
                    data_oe_d  = 1'b0;
                    data_out_d = 8'h00;
                    if (mode_q) begin
                        aeoi_clr_d = (aeoi_q && !spur_q) ? level_onehot(level_q) : 8'h00;
                        freeze_d   = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ACK2;
                    end
                end else if (fall_s && !mode_q) begin
                    data_oe_d  = mux_valid_s;
                    data_out_d = mux_valid_s ? mux_byte_s : 8'h00;
                    state_d    = ST_ACK3;
                end else begin
                    state_d = ST_ACK2;
                end
            end
            ST_ACK3: begin
                if (rise_s) begin
                    data_oe_d  = 1'b0;
                    data_out_d = 8'h00;
                    aeoi_clr_d = (aeoi_q && !spur_q) ? level_onehot(level_q) : 8'h00;
                    freeze_d   = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_ACK3;
                end
            end
            default: begin
                freeze_d   = 1'b0;
                data_oe_d  = 1'b0;
                data_out_d = 8'h00;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State, captured context and registered outputs; reset abandons any sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inta_n_q    <= 1'b1;
            ign_q       <= 1'b1;
            mode_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            spur_q      <= 1'b0;
            level_q     <= 3'd0;
            addr_q      <= 3'd0;
            adi_q       <= 1'b0;
            icw2_q      <= 8'h00;
            int_out_q   <= 1'b0;
            clear_irr_q <= 8'h00;
            set_isr_q   <= 8'h00;
            aeoi_clr_q  <= 8'h00;
            freeze_q    <= 1'b0;
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_n_q    <= inta_n_d;
            ign_q       <= ign_d;
            mode_q      <= mode_d;
            aeoi_q      <= aeoi_d;
            spur_q      <= spur_d;
            level_q     <= level_d;
            addr_q      <= addr_d;
            adi_q       <= adi_d;
            icw2_q      <= icw2_d;
            int_out_q   <= int_out_d;
            clear_irr_q <= clear_irr_d;
            set_isr_q   <= set_isr_d;
            aeoi_clr_q  <= aeoi_clr_d;
            freeze_q    <= freeze_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign int_out      = int_out_q;
    assign clear_irr    = clear_irr_q;
    assign set_isr      = set_isr_q;
    assign aeoi_clr_isr = aeoi_clr_q;
    assign freeze       = freeze_q;
    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;

endmodule
